addsub_multiword: RTL and testbench



---
 rtl/addsub_pkg.sv | 6 +
 rtl/addsub_slice.sv | 29 ++
 rtl/addsub_multiword.sv | 131 +++++++++++++
 tb/tb_addsub_multiword.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and operation codes for the multi-word add/subtract unit
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational WIDTH-bit carry-lookahead adder exposing the carry into the MSB
module addsub_slice #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    assign g = a & b;
    assign p = a ^ b;
    // Each carry is expanded on its own from generate/propagate terms and cin
    always_comb begin
        c = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = cin;
            for (int j = 0; j <= i; j++) c[i+1] = g[j] | (p[j] & c[i+1]);
        end
    end
    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];
    assign cmsb = c[WIDTH-1];
endmodule

// File: rtl/addsub_multiword.sv
// addsub_multiword: multi-cycle slice-serial add/subtract with flags; ADDSUB_SAT_EN enables result clamping
module addsub_multiword #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic                   in_signed,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_result,
    output logic                   out_carry,
    output logic                   out_ovf,
    output logic                   out_zero,
    output logic                   busy
);
    import addsub_pkg::*;

    localparam int TW = WIDTH * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t            state;
    state_t            state_nx;
    logic [TW-1:0]     a_q;
    logic [TW-1:0]     b_q;
    logic              op_q;
    logic              sgn_q;
    logic              carry_q;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  a_s;
    logic [WIDTH-1:0]  b_s;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              cmsb;
    logic              last;
    logic              ovf;
    logic [TW-1:0]     res_nx;
    logic [TW-1:0]     fin;

    assign a_s  = a_q[idx*WIDTH +: WIDTH];
    assign b_s  = (op_q == OP_SUB) ? ~b_q[idx*WIDTH +: WIDTH] : b_q[idx*WIDTH +: WIDTH];
    assign last = (idx == IW'(WORDS - 1));
    assign ovf  = sgn_q ? (cmsb ^ cout) : ((op_q == OP_ADD) ? cout : ~cout);

    addsub_slice #(.WIDTH(WIDTH)) u_slice (
        .a    (a_s),
        .b    (b_s),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout),
        .cmsb (cmsb)
    );

`ifdef ADDSUB_SAT_EN
    localparam logic [TW-1:0] MAX_POS = {TW{1'b1}} >> 1;
    // Merge the current slice, then clamp on overflow toward the bound implied by mode and A's sign
    always_comb begin
        res_nx = out_result;
        res_nx[idx*WIDTH +: WIDTH] = sum;
        fin = ovf ? (sgn_q ? (a_q[TW-1] ? ~MAX_POS : MAX_POS) : ((op_q == OP_SUB) ? '0 : '1)) : res_nx;
    end
`else
    // Merge the current slice into the running result; wrap on overflow
    always_comb begin
        res_nx = out_result;
        res_nx[idx*WIDTH +: WIDTH] = sum;
        fin = res_nx;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state plus the two state-decoded outputs
    always_comb begin
        state_nx = state;
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        if (state == IDLE && in_valid)      state_nx = RUN;
        else if (state == RUN && last)      state_nx = DONE;
        else if (state == DONE && out_ready) state_nx = IDLE;
    end

    // Operand capture, one slice per RUN cycle, flags registered on the final slice
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            sgn_q      <= 1'b0;
            carry_q    <= 1'b0;
            idx        <= '0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
            out_valid  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            op_q       <= in_op;
            sgn_q      <= in_signed;
            carry_q    <= in_op;
            idx        <= '0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (state == RUN) begin
            out_result <= last ? fin : res_nx;
            carry_q    <= cout;
            idx        <= idx + 1'b1;
            if (last) begin
                out_carry <= cout;
                out_ovf   <= ovf;
                out_zero  <= (fin == '0);
                out_valid <= 1'b1;
            end
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_multiword.sv
// tb_addsub_multiword: directed and random checks of addsub_multiword against an integer-arithmetic model
module tb_addsub_multiword;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_op = 1'b0;
    logic        in_signed = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;
    logic        busy;

    int          total = 0;
    int          passed = 0;
    logic [15:0] m_res;
    logic        m_c;
    logic        m_o;
    logic        m_z;

    addsub_multiword #(.WIDTH(4), .WORDS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_signed  (in_signed),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic op, input logic sgn);
        int va;
        int vb;
        int v;
        va = sgn ? int'($signed(a)) : int'(a);
        vb = sgn ? int'($signed(b)) : int'(b);
        v = op ? va - vb : va + vb;
        m_res = v[15:0];
        m_c = op ? (a >= b) : (int'(a) + int'(b) > 65535);
        m_o = sgn ? (v > 32767 || v < -32768) : (v < 0 || v > 65535);
`ifdef ADDSUB_SAT_EN
        if (m_o) m_res = sgn ? (a[15] ? 16'h8000 : 16'h7fff) : (op ? 16'h0000 : 16'hffff);
`endif
        m_z = (m_res == 16'h0);
    endtask

    task automatic start(input logic [15:0] a, input logic [15:0] b, input logic op, input logic sgn);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_req", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_signed = sgn;
        model(a, b, op, sgn);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish(input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_result"}, 32'(out_result), 32'(m_res));
        check({tag, "_carry"}, 32'(out_carry), 32'(m_c));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(m_o));
        check({tag, "_zero"}, 32'(out_zero), 32'(m_z));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_carry", 32'(out_carry), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_zero", 32'(out_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        start(16'h1234, 16'h0034, 1'b1, 1'b0);
        finish("usub_1234_34");
        drain("usub_1234_34");

        start(16'h0005, 16'h0007, 1'b1, 1'b0);
        finish("usub_borrow");
        drain("usub_borrow");

        start(16'hffff, 16'h0001, 1'b0, 1'b0);
        finish("uadd_ripple");
        drain("uadd_ripple");

        start(16'h7fff, 16'h0001, 1'b0, 1'b1);
        finish("sadd_maxpos");
        drain("sadd_maxpos");

        start(16'h8000, 16'h0001, 1'b1, 1'b1);
        finish("ssub_minneg");
        drain("ssub_minneg");

        start(16'h4321, 16'h1111, 1'b0, 1'b0);
        finish("bp_op");
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_op = 1'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_result", 32'(out_result), 32'(m_res));
            check("bp_carry", 32'(out_carry), 32'(m_c));
        end
        in_valid  = 1'b1;
        in_a      = 16'h0100;
        in_b      = 16'h0200;
        in_op     = 1'b0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("simul_not_accepted", 32'(busy), 32'd0);
        check("simul_valid_drop", 32'(out_valid), 32'd0);
        model(16'h0100, 16'h0200, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("simul_accepted", 32'(busy), 32'd1);
        finish("simul");
        drain("simul");

        start(16'(16'h1000 + ($urandom & 16'h0fff)), 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(out_result), 32'd0);
        check("midrst_carry", 32'(out_carry), 32'd0);
        check("midrst_ovf", 32'(out_ovf), 32'd0);
        check("midrst_zero", 32'(out_zero), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        start(16'h00ff, 16'h0001, 1'b0, 1'b0);
        finish("after_rst");
        drain("after_rst");

        for (int i = 0; i < 24; i++) begin
            start(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            finish("rand");
            drain("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
